// File: rtl/bram_arb_pkg.sv
// bram_arb_pkg: shared constants and read-tag type for the BRAM port arbiter
package bram_arb_pkg;
  localparam int WORD_BYTES = 4;
  localparam int WORD_SHIFT = 2;
  localparam int REQ_ID_W = 1;
  typedef logic [REQ_ID_W-1:0] req_id_t;
  typedef struct packed {
    logic    valid;
    req_id_t id;
  } rd_tag_t;
endpackage

// File: rtl/bram_port_arbiter_rd_tag_pipe.sv
// rd_tag_pipe: fixed-depth shift register that follows each granted read to its data return
module rd_tag_pipe
  import bram_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  rd_tag_t din,
  output rd_tag_t dout
);
  rd_tag_t [DEPTH-1:0] stage;
  always_ff @(posedge clk) begin
    if (rst) stage <= '0;
    else stage <= {stage[DEPTH-2:0], din};
  end
  assign dout = stage[DEPTH-1];
endmodule

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: round-robin sharing of one 32-bit BRAM port between two requesters
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 15,
  parameter int READ_LATENCY = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       r0_req,
  input  logic                       r0_we,
  input  logic [WORD_BYTES-1:0]      r0_be,
  input  logic [ADDR_WIDTH-1:0]      r0_addr,
  input  logic [31:0]                r0_wdata,
  output logic                       r0_gnt,
  output logic                       r0_rvalid,
  output logic [31:0]                r0_rdata,
  input  logic                       r1_req,
  input  logic                       r1_we,
  input  logic [WORD_BYTES-1:0]      r1_be,
  input  logic [ADDR_WIDTH-1:0]      r1_addr,
  input  logic [31:0]                r1_wdata,
  output logic                       r1_gnt,
  output logic                       r1_rvalid,
  output logic [31:0]                r1_rdata,
  output logic                       bram_en,
  output logic [WORD_BYTES-1:0]      bram_we,
  output logic [ADDR_WIDTH-3:0]      bram_addr,
  output logic [31:0]                bram_din,
  input  logic [31:0]                bram_dout,
  output logic [1:0]                 misalign
);
  logic                  ptr;
  logic                  any;
  logic                  sel_we;
  logic [WORD_BYTES-1:0] sel_be;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [31:0]           sel_wdata;
  rd_tag_t               tag_in;
  rd_tag_t               tag_out;
  always_comb begin
    r0_gnt = !rst && r0_req && (!r1_req || !ptr);
    r1_gnt = !rst && r1_req && (!r0_req || ptr);
    any = r0_gnt || r1_gnt;
    sel_we = r1_gnt ? r1_we : r0_we;
    sel_be = r1_gnt ? r1_be : r0_be;
    sel_addr = r1_gnt ? r1_addr : r0_addr;
    sel_wdata = r1_gnt ? r1_wdata : r0_wdata;
    tag_in = '{valid: any && !sel_we, id: req_id_t'(r1_gnt)};
  end
  // pointer names the requester that wins the next tie: the one not just served
  always_ff @(posedge clk) begin
    if (rst) begin
      bram_en <= 1'b0;
      bram_we <= '0;
      bram_addr <= '0;
      bram_din <= '0;
      misalign <= '0;
      ptr <= 1'b0;
    end else begin
      bram_en <= any;
      bram_we <= (any && sel_we) ? sel_be : '0;
      if (any) begin
        bram_addr <= sel_addr[ADDR_WIDTH-1:WORD_SHIFT];
        bram_din <= sel_wdata;
        ptr <= r0_gnt;
      end
      misalign <= misalign | {r1_gnt && r1_addr[WORD_SHIFT-1:0] != '0,
                              r0_gnt && r0_addr[WORD_SHIFT-1:0] != '0};
    end
  end
  rd_tag_pipe #(.DEPTH(1 + READ_LATENCY)) u_tags (
    .clk (clk),
    .rst (rst),
    .din (tag_in),
    .dout(tag_out)
  );
  assign r0_rvalid = tag_out.valid && tag_out.id == 1'b0;
  assign r1_rvalid = tag_out.valid && tag_out.id == 1'b1;
  assign r0_rdata = bram_dout;
  assign r1_rdata = bram_dout;
endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb_bram_port_arbiter: scoreboard bench driving READ_LATENCY=1 and =2 arbiters in lockstep
module tb_bram_port_arbiter;
  localparam int AW = 15;
  typedef struct {
    int          due;
    logic [3:0]  we;
    logic [12:0] addr;
    logic [31:0] din;
  } cmd_t;
  typedef struct {
    int          gc;
    logic        id;
    logic [31:0] data;
  } rd_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic r0_req = 1'b0, r0_we = 1'b0, r1_req = 1'b0, r1_we = 1'b0;
  logic [3:0] r0_be = '0, r1_be = '0;
  logic [AW-1:0] r0_addr = '0, r1_addr = '0;
  logic [31:0] r0_wdata = '0, r1_wdata = '0;
  logic [1:0] r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, bram_en;
  logic [31:0] r0_rdata [2], r1_rdata [2], bram_din [2], bram_dout [2];
  logic [3:0] bram_we [2];
  logic [AW-3:0] bram_addr [2];
  logic [1:0] misalign [2];
  int cyc = 0;
  int n_tests = 0, n_fail = 0;
  logic [1:0] mis_exp = 2'b00, mis_set = 2'b00;
  cmd_t cmd_q[$];
  rd_t rq_a[$], rq_b[$];
  logic [31:0] ref_mem [int];
  int prio = 0;
  logic treq [2], twe [2];
  logic [3:0] tbe [2];
  logic [AW-1:0] taddr [2];
  logic [31:0] twd [2];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) mis_exp <= rst ? 2'b00 : (mis_exp | mis_set);
  function automatic logic [31:0] init_word(int a);
    return (a == 4) ? 32'hDEADBEEF : ((32'(a) * 32'h01000193) ^ 32'h5A5A0000);
  endfunction
  function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] d, logic [3:0] be);
    logic [31:0] r = o;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction
  function automatic logic [31:0] ref_rd(int a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction
  for (genvar g = 0; g < 2; g++) begin : gen_dut
    logic [31:0] mem [0:8191];
    logic [8191:0] wr = '0;
    logic [31:0] q1, q2;
    bram_port_arbiter #(.ADDR_WIDTH(AW), .READ_LATENCY(g + 1)) dut (
      .clk(clk), .rst(rst),
      .r0_req(r0_req), .r0_we(r0_we), .r0_be(r0_be), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
      .r0_gnt(r0_gnt[g]), .r0_rvalid(r0_rvalid[g]), .r0_rdata(r0_rdata[g]),
      .r1_req(r1_req), .r1_we(r1_we), .r1_be(r1_be), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
      .r1_gnt(r1_gnt[g]), .r1_rvalid(r1_rvalid[g]), .r1_rdata(r1_rdata[g]),
      .bram_en(bram_en[g]), .bram_we(bram_we[g]), .bram_addr(bram_addr[g]),
      .bram_din(bram_din[g]), .bram_dout(bram_dout[g]), .misalign(misalign[g])
    );
    // read-first BRAM with READ_LATENCY cycles from command to data
    always @(posedge clk) begin
      if (bram_en[g]) begin
        q1 <= wr[bram_addr[g]] ? mem[bram_addr[g]] : init_word(int'(bram_addr[g]));
        if (|bram_we[g]) begin
          mem[bram_addr[g]] <= merge(wr[bram_addr[g]] ? mem[bram_addr[g]] : init_word(int'(bram_addr[g])),
                                     bram_din[g], bram_we[g]);
          wr[bram_addr[g]] <= 1'b1;
        end
      end
    end
    always @(posedge clk) q2 <= q1;
    assign bram_dout[g] = (g == 0) ? q1 : q2;
  end
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask
  task automatic chk_rd(ref rd_t q[$], input int lat, input int g);
    rd_t e;
    if (q.size() != 0 && q[0].gc + 1 + lat == cyc) begin
      e = q.pop_front();
      chk("rvalid", 64'({r1_rvalid[g], r0_rvalid[g]}), e.id ? 64'd2 : 64'd1);
      chk("rdata", 64'(e.id ? r1_rdata[g] : r0_rdata[g]), 64'(e.data));
    end else chk("no_rvalid", 64'({r1_rvalid[g], r0_rvalid[g]}), 64'd0);
  endtask
  initial forever begin
    cmd_t e;
    logic has;
    @(negedge clk);
    if (cyc >= 1) begin
      has = cmd_q.size() != 0 && cmd_q[0].due == cyc;
      if (has) e = cmd_q.pop_front();
      for (int g = 0; g < 2; g++) begin
        if (has) chk("cmd", 64'({bram_en[g], bram_we[g], bram_addr[g], bram_din[g]}),
                     64'({1'b1, e.we, e.addr, e.din}));
        else chk("idle", 64'({bram_en[g], bram_we[g]}), 64'd0);
        chk("misalign", 64'(misalign[g]), 64'(mis_exp));
      end
      chk_rd(rq_a, 1, 0);
      chk_rd(rq_b, 2, 1);
    end
  end
  task automatic set_req(int k, logic we, logic [3:0] be, logic [AW-1:0] a, logic [31:0] wd);
    treq[k] = 1'b1;
    twe[k] = we;
    tbe[k] = be;
    taddr[k] = a;
    twd[k] = wd;
  endtask
  // one cycle: drive, then predict grant and future command/read/misalign effects
  task automatic step(logic r);
    int w, wa;
    @(posedge clk);
    #1;
    rst = r;
    r0_req = treq[0]; r0_we = twe[0]; r0_be = tbe[0]; r0_addr = taddr[0]; r0_wdata = twd[0];
    r1_req = treq[1]; r1_we = twe[1]; r1_be = tbe[1]; r1_addr = taddr[1]; r1_wdata = twd[1];
    @(negedge clk);
    w = -1;
    if (!r) w = (treq[0] && treq[1]) ? prio : treq[0] ? 0 : treq[1] ? 1 : -1;
    for (int g = 0; g < 2; g++)
      chk("gnt", 64'({r1_gnt[g], r0_gnt[g]}), (w < 0) ? 64'd0 : (w == 0) ? 64'd1 : 64'd2);
    mis_set = 2'b00;
    if (r) begin
      prio = 0;
      while (rq_a.size() != 0 && rq_a[$].gc + 2 > cyc) void'(rq_a.pop_back());
      while (rq_b.size() != 0 && rq_b[$].gc + 3 > cyc) void'(rq_b.pop_back());
    end else if (w >= 0) begin
      prio = 1 - w;
      wa = int'(taddr[w] >> 2);
      cmd_q.push_back('{cyc + 1, twe[w] ? tbe[w] : 4'h0, 13'(taddr[w] >> 2), twd[w]});
      if (twe[w]) ref_mem[wa] = merge(ref_rd(wa), twd[w], tbe[w]);
      else begin
        rq_a.push_back('{cyc, w[0], ref_rd(wa)});
        rq_b.push_back('{cyc, w[0], ref_rd(wa)});
      end
      if (taddr[w][1:0] != 2'b00) mis_set[w] = 1'b1;
      treq[w] = 1'b0;
    end
  endtask
  task automatic idle(int n);
    treq[0] = 1'b0;
    treq[1] = 1'b0;
    for (int i = 0; i < n; i++) step(1'b0);
  endtask
  initial begin
    for (int k = 0; k < 2; k++) set_req(k, 1'b0, 4'h0, '0, '0);
    treq[0] = 1'b0;
    treq[1] = 1'b0;
    step(1'b1);
    step(1'b1);
    for (int i = 0; i < 6; i++) begin
      if (!treq[0]) set_req(0, 1'b0, 4'h0, AW'(16 * i), '0);
      if (!treq[1]) set_req(1, 1'b0, 4'h0, AW'(16 * i + 4), '0);
      step(1'b0);
    end
    idle(4);
    set_req(0, 1'b0, 4'hF, AW'(16), '0);
    step(1'b0);
    idle(3);
    for (int i = 0; i < 4; i++) begin
      set_req(1, 1'b1, 4'hF, AW'(256 + 4 * i), $urandom);
      step(1'b0);
    end
    idle(3);
    set_req(0, 1'b1, 4'b0011, AW'(7), 32'h12345678);
    step(1'b0);
    set_req(0, 1'b1, 4'hF, AW'(32), 32'hCAFEF00D);
    set_req(1, 1'b0, 4'h0, AW'(32), '0);
    step(1'b0);
    step(1'b0);
    idle(3);
    set_req(1, 1'b0, 4'h0, AW'(16), '0);
    step(1'b0);
    step(1'b1);
    idle(3);
    set_req(0, 1'b0, 4'h0, AW'(8), '0);
    set_req(1, 1'b0, 4'h0, AW'(12), '0);
    step(1'b0);
    step(1'b0);
    idle(3);
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < 2; k++) begin
        if (!treq[k]) begin
          if ($urandom_range(0, 3) != 0)
            set_req(k, 1'($urandom), 4'($urandom),
                    ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 127)), $urandom);
        end else if ($urandom_range(0, 15) == 0) treq[k] = 1'b0;
      end
      step($urandom_range(0, 199) == 0);
    end
    idle(5);
    chk("drain", 64'(cmd_q.size() + rq_a.size() + rq_b.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
Shares one 32-bit BRAM port (Port A, Zynq PL side) between two requesters: r0 (PS-facing bus bridge) and r1 (PL accelerator).
- Round-robin arbitration; one access per clock.
- Byte address translated to word address (byte_addr[ADDR_WIDTH-1:2]).
- Registered BRAM command.
- Read data routed back to the requester that issued the read, via a latency-matched tag pipeline.

Parameters:
ADDR_WIDTH, 15, requester byte-address width; BRAM word address is ADDR_WIDTH-2 bits
READ_LATENCY, 1, BRAM clock cycles from registered bram_en to valid bram_dout; legal values 1 or 2

Ports:
clk  in  1  system clock, all logic rising-edge
rst  in  1  synchronous reset, active-high
r0_req  in  1  access request; held with fields stable until r0_gnt
r0_we  in  1  1 = write, 0 = read
r0_be  in  4  byte enables for writes; ignored on reads
r0_addr  in  ADDR_WIDTH  byte address
r0_wdata  in  32  write data
r0_gnt  out  1  request accepted this cycle (combinational)
r0_rvalid  out  1  read data valid pulse
r0_rdata  out  32  read data
r1_req, r1_we, r1_be, r1_addr, r1_wdata, r1_gnt, r1_rvalid, r1_rdata  same as r0_*
bram_en  out  1  BRAM enable
bram_we  out  4  BRAM byte write enables
bram_addr  out  ADDR_WIDTH-2  BRAM word address
bram_din  out  32  BRAM write data
bram_dout  in  32  BRAM read data
misalign  out  2  sticky flag per requester: granted access with addr[1:0] != 0

Behaviour:
- Clock and reset:
  - One clock domain (clk).
  - rst is synchronous, active-high.
  - After a reset edge: bram_en=0, bram_we=0, bram_addr=0, bram_din=0, misalign=0, priority pointer=0, tag pipeline cleared.
  - rvalid outputs are 0 in the cycle after the reset edge.
  - gnt outputs are forced 0 while rst=1.
- Arbitration (combinational, cycle T):
  - Only one requester high: it is granted.
  - Both high: the requester selected by the pointer is granted.
  - Pointer update: after a grant to rk, pointer <= other requester. With no grant, pointer is unchanged.
  - At most one gnt per cycle.
  - A lone requester may be granted on consecutive cycles (full throughput).
- Requester rule: hold req and its fields until gnt. Deasserting req before gnt is legal; no access occurs.
- Command (registered, visible at T+1):
  - bram_en=1.
  - bram_addr = winner addr[ADDR_WIDTH-1:2] (exact truncation, no zero-padding).
  - bram_din = winner wdata.
  - bram_we = winner be if we=1, else 4'b0000. A write with be=0 still asserts bram_en.
  - No grant in T: bram_en=0 and bram_we=0 at T+1; bram_addr and bram_din hold their previous values.
- Misalignment: granted access with addr[1:0] != 0 sets misalign[k] at T+1. The flag stays set until rst. The access still proceeds, with address truncated.
- Read return:
  - Granted read at T: tag {valid=1, id=k} enters a shift pipeline of depth 1+READ_LATENCY.
  - At cycle T+1+READ_LATENCY: rk_rvalid=1 for exactly one cycle; rk_rdata = bram_dout (combinational pass-through).
  - rdata for the non-selected requester is also driven from bram_dout and is don't-care when its rvalid=0.
  - Writes produce no rvalid.
  - Return order equals grant order; reads are never dropped or reordered.
- Read-during-write: consecutive write and read to the same word follow BRAM read-first/write-first mode. The arbiter adds no hazard logic.
- Reset mid-operation: in-flight tags are cleared, so no rvalid appears for reads granted before the reset edge. Requesters must reissue.

Decomposition:
- Package bram_arb_pkg holds:
  - WORD_BYTES=4 and WORD_SHIFT=2.
  - REQ_ID width (1 bit).
  - rd_tag_t struct {valid, id}.
- One sub-module, rd_tag_pipe: parameterised shift register of rd_tag_t, depth 1+READ_LATENCY, synchronous clear on rst.
- Arbiter and command register stay in the top.

Test Plan:
- Single r0 read: r0 reads addr 0x0010 at T. Expect:
  - r0_gnt=1 at T.
  - bram_en=1 and bram_addr=0x004 at T+1.
  - bram_dout=0xDEADBEEF gives r0_rvalid=1, r0_rdata=0xDEADBEEF at T+2 (READ_LATENCY=1).
  - r1_rvalid stays 0.
- Contention: r0 and r1 both request reads continuously for 6 cycles from reset. Expect grant order r0,r1,r0,r1,r0,r1 and rvalid order identical, each delayed 2 cycles.
- Lone streaming: r1 issues 4 back-to-back writes to 0x0100..0x010C with be=4'hF. Expect:
  - gnt every cycle.
  - bram_addr 0x040..0x043.
  - bram_we=4'hF.
  - No rvalid.
- Misaligned write: r0 writes addr 0x0007 with be=4'b0011. Expect bram_addr=0x001, bram_we=4'b0011, misalign=2'b01 thereafter until rst.
- Reset mid-flight: READ_LATENCY=2, r1 read granted at T, rst=1 at T+1. Expect no r1_rvalid at T+3, and bram_en=0 and pointer=0 after reset.
- Mixed: r0 write and r1 read requested at the same cycle with pointer=1. Expect:
  - r1 granted first with bram_we=0.
  - r0 granted the next cycle.
  - Only r1_rvalid pulses.
